div_iter: RTL and testbench

- Parametrised multi-cycle integer divider; next generation of the CPU's unsigned 32-bit divider.
- Adds configurable width and per-operation signed/unsigned mode, so one block serves both DIV and DIVU.
- Adds defined divide-by-zero behaviour, back-to-back issue, and held result registers.
- Sits beside the ALU in EX and is stalled on busy; non-restoring algorithm, one quotient bit per cycle.

---
 rtl/div_iter_if.sv | 25 ++
 rtl/div_iter.sv | 127 ++++++++++++
 tb/tb_div_iter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - request/result bundle between the EX stage and the iterative divider
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   r;
  logic [2*WIDTH-1:0] z;
  logic               busy;
  logic               ready;
  logic               div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  q, r, z, busy, ready, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output q, r, z, busy, ready, div_by_zero
  );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - non-restoring signed/unsigned divider, one quotient bit per cycle
// Results are held in registers from completion until the next completion.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  div_iter_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             sgnq_q,  sgnq_d;
  logic             sgnr_q,  sgnr_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             dbz_q,   dbz_d;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, step, rem_fix;
  logic [WIDTH-1:0] quo_next;

  // Operand magnitudes; unsigned mode never negates.
  assign neg_a = bus.is_signed & bus.dividend[WIDTH-1];
  assign neg_b = bus.is_signed & bus.divisor[WIDTH-1];
  assign mag_a = neg_a ? -bus.dividend : bus.dividend;
  assign mag_b = neg_b ? -bus.divisor  : bus.divisor;

  // Sign of the old partial remainder picks subtract or add-back.
  assign shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign step     = rem_q[WIDTH] ? (shifted + {1'b0, dvs_q}) : (shifted - {1'b0, dvs_q});
  assign quo_next = {quo_q[WIDTH-2:0], ~step[WIDTH]};
  assign rem_fix  = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            q_d     = '1;
            r_d     = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            sgnq_d  = neg_a ^ neg_b;
            sgnr_d  = neg_a;
            quo_d   = mag_a;
            dvs_d   = mag_b;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        rem_d = step;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        rem_d   = rem_fix;
        q_d     = sgnq_q ? -quo_q : quo_q;
        r_d     = sgnr_q ? -rem_fix[WIDTH-1:0] : rem_fix[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ITER) || (state_q == FIX);
  assign bus.ready       = (state_q == DONE);
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.z           = {r_q, q_q};
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed and random scoreboard bench for div_iter
module tb_div_iter;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  div_iter_if #(.WIDTH(W)) bus();
  div_iter #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb_l;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (sgn) begin
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      e.q  = W'(sa / sb_l);
      e.r  = W'(sa % sb_l);
      e.dbz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(sgn, a, b));
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(input int poke_at, output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int n = 0; n < 100; n++) begin
      if (bus.ready) begin
        lat = n;
        break;
      end
      if (bus.busy) bc++;
      if (n == poke_at) begin
        bus.start = 1'b1; bus.is_signed = 1'b0;
        bus.dividend = 32'd1234; bus.divisor = 32'd5;
      end else if (n == poke_at + 1) begin
        bus.start = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic check_out(input string tag, input int lat_exp, input int bc_exp,
                           input int lat, input int bc);
    exp_t e;
    chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(bc_exp));
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 64'(bus.q), 64'(e.q));
      chk({tag, "_r"}, 64'(bus.r), 64'(e.r));
      chk({tag, "_z"}, bus.z, {e.r, e.q});
      chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat_exp, input int bc_exp);
    int lat, bc;
    issue(sgn, a, b);
    wait_ready(-1, lat, bc);
    check_out(tag, lat_exp, bc_exp, lat, bc);
    @(negedge clock);
    chk({tag, "_ready_pulse"}, 64'(bus.ready), 64'd0);
  endtask

  initial begin
    int lat, bc, seen;
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_z", bus.z, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("u100_7", 1'b0, 32'd100, 32'd7, W + 1, W + 1);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, W + 1, W + 1);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, W + 1, W + 1);
    run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, W + 1);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, W + 1, W + 1);
    run_op("s_m1_1", 1'b1, 32'hFFFF_FFFF, 32'd1, W + 1, W + 1);
    run_op("u_3_msb", 1'b0, 32'd3, 32'h8000_0000, W + 1, W + 1);
    run_op("s_5_0", 1'b1, 32'd5, 32'd0, 0, 0);
    run_op("u_9_3", 1'b0, 32'd9, 32'd3, W + 1, W + 1);

    // Start pulsed mid-operation is ignored; start in DONE chains a new op.
    issue(1'b0, 32'd100, 32'd7);
    wait_ready(10, lat, bc);
    check_out("ignore_mid", W + 1, W + 1, lat, bc);
    issue(1'b0, 32'd1000, 32'd10);
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    wait_ready(-1, lat, bc);
    check_out("b2b_second", W + 1, W + 1, lat, bc);
    @(negedge clock);

    // Asynchronous reset in the middle of an operation.
    issue(1'b0, 32'd100, 32'd7);
    repeat (15) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.ready), 64'd0);
    chk("mid_rst_q", 64'(bus.q), 64'd0);
    chk("mid_rst_r", 64'(bus.r), 64'd0);
    chk("mid_rst_dbz", 64'(bus.div_by_zero), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.ready) seen++;
    end
    chk("mid_rst_no_ready", 64'(seen), 64'd0);
    run_op("after_rst", 1'b0, 32'd100, 32'd7, W + 1, W + 1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == '0) rb = 32'd3;
      run_op((i % 2) ? "rnd_s" : "rnd_u", logic'(i % 2), ra, rb, W + 1, W + 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
